// File: rtl/cfg_delay_buffer_if.sv
// rtl/cfg_delay_buffer_if.sv - control, stream and status bundle of the alignment delay line
interface cfg_delay_buffer_if #(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 17,
  parameter int DEPTH_W = 5
);
  logic                       en;
  logic                       flush;
  logic                       cfg_load;
  logic [DEPTH_W-1:0]         delay_cfg;
  logic                       din_valid;
  logic [NUM_CH*DATA_W-1:0]   din;
  logic                       dout_valid;
  logic [NUM_CH*DATA_W-1:0]   dout;
  logic [DEPTH_W-1:0]         depth;
  logic [DEPTH_W-1:0]         fill_cnt;
  logic                       cfg_busy;

  // Producer side: drives controls and input words, observes the tap and status.
  modport master (
    output en, flush, cfg_load, delay_cfg, din_valid, din,
    input  dout_valid, dout, depth, fill_cnt, cfg_busy
  );

  // Delay line side.
  modport slave (
    input  en, flush, cfg_load, delay_cfg, din_valid, din,
    output dout_valid, dout, depth, fill_cnt, cfg_busy
  );
endinterface

// File: rtl/cfg_delay_buffer.sv
// rtl/cfg_delay_buffer.sv - multi-lane delay line with run-time depth, stall, flush and fill status
module cfg_delay_buffer #(
  parameter int                NUM_CH        = 8,
  parameter int                DATA_W        = 17,
  parameter int                MAX_DEPTH     = 16,
  parameter int                DEFAULT_DEPTH = 13,
  parameter logic [DATA_W-1:0] RST_VAL       = '1,
  parameter int                DEPTH_W       = $clog2(MAX_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,  // active-high asynchronous reset despite the name
  cfg_delay_buffer_if.slave     bus
);

  localparam int W = NUM_CH * DATA_W;
  localparam logic [W-1:0]       FILL_WORD = {NUM_CH{RST_VAL}};
  localparam logic [DEPTH_W-1:0] MAX_D     = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] DEF_D     = DEPTH_W'(DEFAULT_DEPTH);

  // stage_data[i] / stage_valid[i] is stage S(i+1)
  logic [W-1:0]         stage_data [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] stage_valid;
  logic [DEPTH_W-1:0]   depth_q;
  logic [DEPTH_W-1:0]   fill_q;
  logic [W-1:0]         in_word;
  logic                 clear;

  // Bubbles enter as the sentinel so a downstream write port sees a no-op on every lane.
  assign in_word = bus.din_valid ? bus.din : FILL_WORD;
  assign clear   = bus.flush | bus.cfg_load;

  // Stage shift register; reset and clear return every stage to sentinel/invalid.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        stage_data[i] <= FILL_WORD;
      end
      stage_valid <= '0;
    end else if (clear) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        stage_data[i] <= FILL_WORD;
      end
      stage_valid <= '0;
    end else if (bus.en) begin
      stage_data[0] <= in_word;
      for (int i = 1; i < MAX_DEPTH; i++) begin
        stage_data[i] <= stage_data[i-1];
      end
      stage_valid <= {stage_valid[MAX_DEPTH-2:0], bus.din_valid};
    end
  end

  // Active depth: only cfg_load changes it, with oversize requests clamped to the storage size.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      depth_q <= DEF_D;
    end else if (bus.cfg_load) begin
      depth_q <= (bus.delay_cfg > MAX_D) ? MAX_D : bus.delay_cfg;
    end
  end

  // Fill counter: enabled cycles since the last clear, saturating at the active depth.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fill_q <= '0;
    end else if (clear) begin
      fill_q <= '0;
    end else if (bus.en && (fill_q < depth_q)) begin
      fill_q <= fill_q + 1'b1;
    end
  end

  // Tap select: registered stage S_D, or straight pass-through when the depth is zero.
  always_comb begin
    bus.dout       = FILL_WORD;
    bus.dout_valid = 1'b0;
    if (depth_q == '0) begin
      bus.dout       = bus.din;
      bus.dout_valid = bus.din_valid;
    end else begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        if (depth_q == DEPTH_W'(i + 1)) begin
          bus.dout       = stage_data[i];
          bus.dout_valid = stage_valid[i];
        end
      end
    end
  end

  assign bus.depth    = depth_q;
  assign bus.fill_cnt = fill_q;
  assign bus.cfg_busy = (fill_q < depth_q);

endmodule
